// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BURST  = 2'b01,
    YIELD  = 2'b10
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with clear priority; flags when the count sits at MAX.
module sat_counter #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared synchronous memory port: CPU default
// priority, DMA starvation guard and bounded locked bursts.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t r_state, w_next;
  logic       w_wait_max, w_burst_last, w_arb_dma;
  logic       r_rvalid, r_owner;

  sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (dma_req && !dma_gnt && (r_state != YIELD)),
    .i_clr    (dma_gnt || !dma_req),
    .o_at_max (w_wait_max)
  );

  // Saturates one below BURST_MAX so at-max marks the grant that ends the burst.
  sat_counter #(.MAX(BURST_MAX - 1)) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (dma_gnt && ((r_state == BURST) || ((r_state == NORMAL) && dma_lock))),
    .i_clr    (w_next == NORMAL),
    .o_at_max (w_burst_last)
  );

  assign w_arb_dma = dma_req && (!cpu_req || w_wait_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= NORMAL;
    else     r_state <= w_next;
  end

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    w_next  = r_state;
    if (!rst) begin
      case (r_state)
        NORMAL: begin
          dma_gnt = w_arb_dma;
          cpu_gnt = cpu_req && !w_arb_dma;
          if (w_arb_dma && dma_lock) w_next = (BURST_MAX == 1) ? YIELD : BURST;
        end
        BURST: begin
          if (dma_req) begin
            dma_gnt = 1'b1;
            if (w_burst_last)   w_next = YIELD;
            else if (!dma_lock) w_next = NORMAL;
          end else begin
            cpu_gnt = cpu_req;
            w_next  = NORMAL;
          end
        end
        YIELD: begin
          cpu_gnt = cpu_req;
          dma_gnt = dma_req && !cpu_req;
          w_next  = NORMAL;
        end
        default: w_next = NORMAL;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign mem_en = cpu_gnt | dma_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_owner  <= OWN_CPU;
    end else begin
      r_rvalid <= mem_en && !mem_we;
      r_owner  <= dma_gnt ? OWN_DMA : OWN_CPU;
    end
  end

  assign cpu_rvalid = r_rvalid && (r_owner == OWN_CPU);
  assign dma_rvalid = r_rvalid && (r_owner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a behavioural model.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 8;
  localparam int BM = 4;

  logic          clk, rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the strobe.
  logic [DW-1:0] mem_arr [256];
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i * 257) ^ 16'hA5A5;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
        else        mem_rdata <= mem_arr[mem_addr[7:0]];
      end
    end
  end

  int n_chk, n_err;

  // Reference model: wait cycles, locked grants in the current burst, yield flag.
  int            m_wait, m_run;
  bit            m_yield;
  logic [DW-1:0] sh [256];
  bit            p_cpu_rv, p_dma_rv;
  logic [DW-1:0] p_data;

  bit            ob_cgnt, ob_dgnt, ob_we, ob_cpu_rv, ob_dma_rv;
  logic [AW-1:0] ob_addr;
  logic [DW-1:0] ob_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_run    = 0;
    m_yield  = 1'b0;
    p_cpu_rv = 1'b0;
    p_dma_rv = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks at the falling edge.
  task automatic cycle_chk();
    bit ec, ed, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    #4;
    if (m_yield) begin
      ec = cpu_req;
      ed = dma_req && !cpu_req;
    end else if (m_run > 0 && dma_req) begin
      ec = 1'b0;
      ed = 1'b1;
    end else begin
      ed = dma_req && (!cpu_req || m_wait == MW);
      ec = cpu_req && !ed;
    end
    ewe = ec ? cpu_we    : (ed ? dma_we    : 1'b0);
    ea  = ec ? cpu_addr  : (ed ? dma_addr  : '0);
    ewd = ec ? cpu_wdata : (ed ? dma_wdata : '0);
    chk("cpu_gnt",    32'(cpu_gnt),    32'(ec));
    chk("dma_gnt",    32'(dma_gnt),    32'(ed));
    chk("mem_en",     32'(mem_en),     32'(ec | ed));
    chk("mem_we",     32'(mem_we),     32'(ewe));
    chk("mem_addr",   32'(mem_addr),   32'(ea));
    chk("mem_wdata",  32'(mem_wdata),  32'(ewd));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_cpu_rv));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(p_dma_rv));
    if (p_cpu_rv) chk("cpu_rdata", 32'(cpu_rdata), 32'(p_data));
    if (p_dma_rv) chk("dma_rdata", 32'(dma_rdata), 32'(p_data));
    ob_cgnt = cpu_gnt;     ob_dgnt = dma_gnt;
    ob_we = mem_we;        ob_addr = mem_addr;    ob_wdata = mem_wdata;
    ob_cpu_rv = cpu_rvalid; ob_dma_rv = dma_rvalid;
    p_cpu_rv = ec && !cpu_we;
    p_dma_rv = ed && !dma_we;
    if (ec || ed) begin
      if (ewe) sh[ea[7:0]] = ewd;
      else     p_data = sh[ea[7:0]];
    end
    if (dma_req && !ed) begin
      if (!m_yield && m_wait < MW) m_wait++;
    end else begin
      m_wait = 0;
    end
    if (!m_yield && ed && (m_run > 0 || dma_lock)) begin
      if (m_run + 1 == BM) begin
        m_yield = 1'b1;
        m_run   = 0;
      end else begin
        m_run = dma_lock ? m_run + 1 : 0;
      end
    end else begin
      m_yield = 1'b0;
      m_run   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002; dma_wdata = '0; dma_lock = 1'b0;
    #2;
    chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    chk("rst_dma_gnt",    32'(dma_gnt),    32'd0);
    chk("rst_mem_en",     32'(mem_en),     32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic rand_in();
    if (!(cpu_req && !ob_cgnt)) begin
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
    end
    if (!(dma_req && !ob_dgnt)) begin
      dma_req   = ($urandom_range(0, 1) == 1);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = 16'($urandom);
      dma_wdata = 16'($urandom);
    end
    dma_lock = ($urandom_range(0, 3) != 0);
  endtask

  int first_d, second_d, run, max_run, total_d;
  bit gd [26];

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) sh[i] = 16'(i * 257) ^ 16'hA5A5;
    do_reset();

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    cycle_chk();
    cpu_we = 1'b0;
    cycle_chk();
    chk("beef_gnt",    32'(ob_cgnt),    32'd1);
    chk("beef_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("beef_rdata",  32'(cpu_rdata),  32'h0000BEEF);
    cpu_req = 1'b0;
    cycle_chk();

    // Starvation guard with both requesting, no lock
    do_reset();
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
    first_d = -1; second_d = -1;
    for (int i = 0; i < 18; i++) begin
      cycle_chk();
      if (ob_dgnt) begin
        if (first_d < 0) first_d = i;
        else if (second_d < 0) second_d = i;
      end
    end
    chk("starve_first",  32'(first_d),  32'd8);
    chk("starve_second", 32'(second_d), 32'd17);

    // Locked burst bounded, then yield
    do_reset();
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 26; i++) begin
      cycle_chk();
      gd[i] = ob_dgnt;
    end
    first_d = -1; second_d = -1; run = 0; max_run = 0; total_d = 0;
    for (int i = 0; i < 26; i++) begin
      if (gd[i]) begin
        total_d++;
        run++;
        if (run > max_run) max_run = run;
        if (first_d < 0) first_d = i;
        else if (i > 0 && !gd[i-1] && second_d < 0) second_d = i;
      end else begin
        run = 0;
      end
    end
    chk("burst_start",  32'(first_d),  32'd8);
    chk("burst_maxrun", 32'(max_run),  32'd4);
    chk("burst_yield",  32'(gd[12]),   32'd0);
    chk("burst_again",  32'(second_d), 32'd21);
    chk("burst_total",  32'(total_d),  32'd8);

    // DMA write with CPU idle
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h1234;
    cycle_chk();
    chk("dwr_we",    32'(ob_we),    32'd1);
    chk("dwr_addr",  32'(ob_addr),  32'h0200);
    chk("dwr_wdata", 32'(ob_wdata), 32'h1234);
    dma_req = 1'b0;
    cycle_chk();
    chk("dwr_no_drv", 32'(ob_dma_rv), 32'd0);
    chk("dwr_no_crv", 32'(ob_cpu_rv), 32'd0);

    // Reset between a DMA read grant and its return
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0033; cpu_req = 1'b0;
    #4;
    chk("mid_dma_gnt", 32'(dma_gnt), 32'd1);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_drv", 32'(dma_rvalid), 32'd0);
    rst = 1'b0;
    model_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
    cycle_chk();
    chk("mid_cpu_first", 32'(ob_cgnt),   32'd1);
    chk("mid_drv_after", 32'(ob_dma_rv), 32'd0);

    // DMA drops its request mid-burst
    do_reset();
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 10; i++) cycle_chk();
    chk("drop_in_burst", 32'(ob_dgnt), 32'd1);
    dma_req = 1'b0;
    cycle_chk();
    chk("drop_cpu", 32'(ob_cgnt), 32'd1);
    dma_req = 1'b1;
    cycle_chk();
    chk("drop_normal_cpu", 32'(ob_cgnt), 32'd1);
    chk("drop_normal_dma", 32'(ob_dgnt), 32'd0);

    // Random traffic
    do_reset();
    ob_cgnt = 1'b0;
    ob_dgnt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rand_in();
      cycle_chk();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
